flash_ctrl: RTL and testbench
=============================

Name: flash_ctrl

Overview:
- Sequencing controller and arbiter placed in front of the boot flash macro.
- Shares the single flash port between two requesters:
  - the instruction-fetch port, which is read-only;
  - the data port, which supports read, program and erase.
- Turns each request into a one-cycle flash command strobe, waits out the flash internal states and busy, and returns read data and an error flag with a one-cycle ack.

Parameters:
- FETCH_PRIO, 0: 0 = round-robin between ports on simultaneous requests; 1 = fetch always wins.
- BUSY_TIMEOUT, 15: maximum cycles to wait in SETTLE for fl_busy=0 before the access is aborted with an error.
- LOCK_WORDS, 0: program requests to word index < LOCK_WORDS, and all erase requests when LOCK_WORDS != 0, are rejected without touching the flash.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  12  fetch byte address
- if_rdata  out  32  fetch read data, valid with if_ack
- if_ack  out  1  one-cycle fetch completion
- if_err  out  1  valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_op  in  2  00 read, 01 program, 10 erase, 11 illegal
- d_addr  in  12  data byte address
- d_wdata  in  32  program data
- d_rdata  out  32  data read result, valid with d_ack
- d_ack  out  1  one-cycle data completion
- d_err  out  1  valid with d_ack
- fl_rd_en, fl_wr_en, fl_erase_en  out  1 each  flash command strobes
- fl_addr  out  12  flash address
- fl_idata  out  32  flash write data
- fl_odata  in  32  flash read data
- fl_busy  in  1  flash busy
- fl_error  in  1  flash error

Behaviour:
- Reset values:
  - all outputs 0;
  - state = INIT;
  - rr_last = data, so fetch wins the first tie;
  - timeout counter = 0.
- States: INIT, IDLE, ISSUE, WAIT, SETTLE, RESP.
- INIT:
  - lasts 2 cycles after rst deasserts, so any flash operation in flight before reset can drain;
  - requests are ignored; then IDLE.
- Requester rules:
  - req, addr, op and wdata are held stable until ack;
  - ack is a single-cycle pulse;
  - a new request may be presented the cycle after ack.
- IDLE, arbitration and latching:
  - If any request is pending: arbitrate, latch the winner's op/addr/wdata, go to ISSUE.
  - FETCH_PRIO=0: on a tie, grant the port not served last; rr_last updates on each grant.
  - Fetch is always treated as op=read.
- IDLE, rejection:
  - These requests go straight to RESP with err=1 and no flash strobe:
    - addr[1:0] != 0;
    - d_op = 11;
    - a lock violation.
  - For a rejected request, rdata is unchanged.
- ISSUE:
  - Exactly one strobe is high for exactly one cycle.
  - fl_addr and fl_idata are driven from the latched values; they remain stable from ISSUE through SETTLE.
  - Next state WAIT.
- WAIT:
  - Capture fl_odata into the requester's rdata register when the op is read.
  - Capture fl_error into an err register; program to a non-erased word yields err=1.
  - Next state SETTLE.
- SETTLE:
  - Stay while fl_busy=1; the counter increments each cycle.
  - Leave for RESP the first cycle fl_busy=0.
  - If the counter reaches BUSY_TIMEOUT, go to RESP with err=1.
- RESP:
  - Pulse ack and err on the granted port only; the other port's ack stays 0.
  - Clear the counter, go to IDLE.
- Latency (req first seen in IDLE at cycle 0):
  - read: ack at cycle 4;
  - program/erase: ack at cycle 5, since busy is high for one SETTLE cycle;
  - rejected request: ack at cycle 1.
- Throughput: back-to-back requests from one port are spaced 5 and 6 cycles apart respectively.
- Concurrency: the losing port's request is held pending and is granted in the IDLE cycle immediately after RESP.
- Never more than one outstanding flash command; strobes are never asserted outside ISSUE.
- Erase ignores the address; fl_addr is driven with the latched address.
- rst asserted in any state:
  - the next cycle is INIT, all strobes and acks are 0;
  - the in-flight request is dropped without ack;
  - rdata registers are cleared.

Test Plan:
- Fetch read, flash word[5]=0xE3A00001: if_req, if_addr=0x014 -> fl_rd_en pulses once at cycle 1 with fl_addr=0x014; if_ack=1 at cycle 4, if_rdata=0xE3A00001, if_err=0.
- Erase then program: erase -> d_ack at cycle 5, d_err=0; then program 0xDEADBEEF to 0x008 -> d_err=0, and a fetch read of 0x008 returns 0xDEADBEEF; reprogram 0x008 without erase -> d_err=1, contents unchanged.
- Simultaneous if_req and d_req every cycle, FETCH_PRIO=0 -> grants alternate fetch, data, fetch, data; FETCH_PRIO=1 -> fetch served every time while if_req stays asserted.
- d_addr=0x006 or d_op=11 -> d_ack at cycle 1 with d_err=1, no strobe; LOCK_WORDS=4, program to 0x00C -> rejected, to 0x010 -> accepted.
- Flash model holding fl_busy=1 for 20 cycles -> d_ack with d_err=1 exactly BUSY_TIMEOUT cycles after entering SETTLE.
- rst asserted during SETTLE -> no ack; all outputs 0; no request accepted for 2 cycles after rst deasserts; next read completes normally.

Source files
------------

// File: rtl/flash_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module  : flash_ctrl_if
// Brief   : Requester-side bundle of flash_ctrl (fetch port + data port).
// Revision: 1.0
// =============================================================================
interface flash_ctrl_if;
    logic        if_req;
    logic [11:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;
    logic        d_req;
    logic [1:0]  d_op;
    logic [11:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;

    modport master (
        output if_req, if_addr, d_req, d_op, d_addr, d_wdata,
        input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err
    );

    modport slave (
        input  if_req, if_addr, d_req, d_op, d_addr, d_wdata,
        output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err
    );
endinterface
`default_nettype wire

// File: rtl/flash_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : flash_ctrl
// Brief   : Arbitrates fetch/data requesters onto one flash port and sequences
//           each access (strobe, capture, busy wait, one-cycle ack).
// Revision: 1.0
// =============================================================================
module flash_ctrl #(
    parameter int FETCH_PRIO   = 0,
    parameter int BUSY_TIMEOUT = 15,
    parameter int LOCK_WORDS   = 0
) (
    input  wire         clk,
    input  wire         rst,
    flash_ctrl_if.slave bus,
    output logic        fl_rd_en,
    output logic        fl_wr_en,
    output logic        fl_erase_en,
    output logic [11:0] fl_addr,
    output logic [31:0] fl_idata,
    input  wire  [31:0] fl_odata,
    input  wire         fl_busy,
    input  wire         fl_error
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int               CNT_W       = $clog2(BUSY_TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(BUSY_TIMEOUT);
    localparam logic [10:0]      LOCK_IDX    = 11'(LOCK_WORDS);

    logic [2:0]       r_state;
    logic             r_init_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rr_last;
    logic             r_port;
    logic [1:0]       r_op;
    logic [11:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_err;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_d_rdata;

    logic             w_grant_d;
    logic [1:0]       w_op;
    logic [11:0]      w_addr;
    logic             w_lock;
    logic             w_reject;
    logic [CNT_W-1:0] w_cnt_inc;

    // Winner selection and admission check are evaluated every cycle but only
    // consumed in IDLE.
    always_comb begin
        w_grant_d = bus.d_req;
        if (bus.if_req && bus.d_req) begin
            w_grant_d = (FETCH_PRIO == 0) ? (r_rr_last == PORT_F) : 1'b0;
        end
        w_op     = w_grant_d ? bus.d_op   : OP_READ;
        w_addr   = w_grant_d ? bus.d_addr : bus.if_addr;
        w_lock   = (LOCK_WORDS != 0) &&
                   ((w_op == OP_ERASE) ||
                    ((w_op == OP_PROG) && ({1'b0, w_addr[11:2]} < LOCK_IDX)));
        w_reject = (w_addr[1:0] != 2'b00) || (w_op == OP_ILL) || w_lock;
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= 1'b0;
            r_cnt      <= '0;
            r_rr_last  <= PORT_D;
            r_port     <= PORT_F;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_init_cnt <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        r_port    <= w_grant_d;
                        r_rr_last <= w_grant_d;
                        r_op      <= w_op;
                        r_addr    <= w_addr;
                        r_wdata   <= w_grant_d ? bus.d_wdata : 32'd0;
                        r_err     <= w_reject;
                        r_state   <= w_reject ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_op == OP_READ) begin
                        if (r_port == PORT_D) begin
                            r_d_rdata <= fl_odata;
                        end else begin
                            r_if_rdata <= fl_odata;
                        end
                    end
                    r_err   <= fl_error;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!fl_busy) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Abort once the busy wait has consumed its budget.
                        if (w_cnt_inc == TIMEOUT_VAL) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign fl_rd_en    = (r_state == S_ISSUE) && (r_op == OP_READ);
    assign fl_wr_en    = (r_state == S_ISSUE) && (r_op == OP_PROG);
    assign fl_erase_en = (r_state == S_ISSUE) && (r_op == OP_ERASE);
    assign fl_addr     = r_addr;
    assign fl_idata    = r_wdata;

    assign bus.if_ack   = (r_state == S_RESP) && (r_port == PORT_F);
    assign bus.if_err   = bus.if_ack && r_err;
    assign bus.d_ack    = (r_state == S_RESP) && (r_port == PORT_D);
    assign bus.d_err    = bus.d_ack && r_err;
    assign bus.if_rdata = r_if_rdata;
    assign bus.d_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_flash_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_flash_ctrl
// Brief   : Directed self-checking bench for flash_ctrl with a small flash model.
// Revision: 1.0
// =============================================================================
module tb_flash_ctrl;

    localparam logic PF = 1'b0;
    localparam logic PD = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    flash_ctrl_if bus ();
    flash_ctrl_if bus2 ();

    logic        fl_rd_en, fl_wr_en, fl_erase_en;
    logic [11:0] fl_addr;
    logic [31:0] fl_idata;
    logic [31:0] fl_odata  = 32'd0;
    logic        fl_busy   = 1'b0;
    logic        fl_error  = 1'b0;

    logic        f2_rd, f2_wr, f2_er;
    logic [11:0] f2_addr;
    logic [31:0] f2_idata;

    flash_ctrl #(.FETCH_PRIO(0), .BUSY_TIMEOUT(15), .LOCK_WORDS(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fl_rd_en   (fl_rd_en),
        .fl_wr_en   (fl_wr_en),
        .fl_erase_en(fl_erase_en),
        .fl_addr    (fl_addr),
        .fl_idata   (fl_idata),
        .fl_odata   (fl_odata),
        .fl_busy    (fl_busy),
        .fl_error   (fl_error)
    );

    flash_ctrl #(.FETCH_PRIO(1), .BUSY_TIMEOUT(15), .LOCK_WORDS(4)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2),
        .fl_rd_en   (f2_rd),
        .fl_wr_en   (f2_wr),
        .fl_erase_en(f2_er),
        .fl_addr    (f2_addr),
        .fl_idata   (f2_idata),
        .fl_odata   (32'hA5A5_0000),
        .fl_busy    (1'b0),
        .fl_error   (1'b0)
    );

    // Flash model: data one cycle after the strobe, busy starts the cycle after that.
    logic [31:0] mem [0:1023];
    logic        mem_ready  = 1'b0;
    logic        busy_pend  = 1'b0;
    int          busy_rem   = 0;
    int          busy_len   = 1;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
            mem[5]    <= 32'hE3A0_0001;
            mem_ready <= 1'b1;
        end else begin
            if (fl_rd_en) begin
                fl_odata <= mem[fl_addr[11:2]];
                fl_error <= 1'b0;
            end
            if (fl_wr_en) begin
                if (mem[fl_addr[11:2]] != 32'hFFFF_FFFF) begin
                    fl_error <= 1'b1;
                end else begin
                    fl_error <= 1'b0;
                    mem[fl_addr[11:2]] <= fl_idata;
                end
            end
            if (fl_erase_en) begin
                for (int i = 0; i < 1024; i++) mem[i] <= 32'hFFFF_FFFF;
                fl_error <= 1'b0;
            end
            busy_pend <= fl_wr_en | fl_erase_en;
            if (busy_pend) begin
                fl_busy  <= 1'b1;
                busy_rem <= busy_len - 1;
            end else if (fl_busy) begin
                if (busy_rem == 0) fl_busy <= 1'b0;
                else busy_rem <= busy_rem - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Runs one request on dut; called and returns one step after a posedge.
    task automatic do_req(input string nm, input logic port, input logic [1:0] op,
                          input logic [11:0] addr, input logic [31:0] wd, input int lat,
                          input logic eerr, input logic chk_rd, input logic [31:0] erd,
                          input int nstrb, input int sk);
        logic [2:0] es;
        int strb;
        int got;
        logic other;
        es = (port == PF || op == 2'b00) ? 3'b100 : (op == 2'b01) ? 3'b010 : 3'b001;
        strb = 0; got = -1; other = 1'b0;
        if (port == PF) begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end else begin
            bus.d_req = 1'b1; bus.d_op = op; bus.d_addr = addr; bus.d_wdata = wd;
        end
        for (int k = 0; k < 64 && got < 0; k++) begin
            @(negedge clk);
            if (fl_rd_en || fl_wr_en || fl_erase_en) begin
                strb++;
                chk({nm, " strobe"}, 32'({fl_rd_en, fl_wr_en, fl_erase_en}), 32'(es));
                chk({nm, " strobe cycle"}, 32'(k), 32'(sk));
                chk({nm, " fl_addr"}, 32'(fl_addr), 32'(addr));
                if (es == 3'b010) chk({nm, " fl_idata"}, fl_idata, wd);
            end
            if (port == PF ? bus.d_ack : bus.if_ack) other = 1'b1;
            if (port == PF ? bus.if_ack : bus.d_ack) begin
                got = k;
                chk({nm, " err"}, 32'(port == PF ? bus.if_err : bus.d_err), 32'(eerr));
                if (chk_rd) chk({nm, " rdata"}, port == PF ? bus.if_rdata : bus.d_rdata, erd);
            end
        end
        chk({nm, " ack cycle"}, 32'(got), 32'(lat));
        chk({nm, " strobe count"}, 32'(strb), 32'(nstrb));
        chk({nm, " other ack"}, 32'(other), 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
    endtask

    // Data-port request on dut2 (FETCH_PRIO=1, LOCK_WORDS=4, flash never busy).
    task automatic lock_req(input string nm, input logic [1:0] op, input logic [11:0] addr,
                            input int lat, input logic eerr, input int nstrb);
        int strb;
        int got;
        strb = 0; got = -1;
        bus2.d_req = 1'b1; bus2.d_op = op; bus2.d_addr = addr; bus2.d_wdata = 32'h0000_1234;
        for (int k = 0; k < 32 && got < 0; k++) begin
            @(negedge clk);
            if (f2_rd || f2_wr || f2_er) strb++;
            if (bus2.d_ack) begin
                got = k;
                chk({nm, " err"}, 32'(bus2.d_err), 32'(eerr));
            end
        end
        chk({nm, " ack cycle"}, 32'(got), 32'(lat));
        chk({nm, " strobe count"}, 32'(strb), 32'(nstrb));
        @(posedge clk); #1;
        bus2.d_req = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        int          nstrb;
    } vec_t;

    vec_t tbl [9];
    logic gport [4];
    int   gk    [4];
    int   n;
    int   got;
    logic bad;

    initial begin
        tbl[0] = '{PF, 2'b00, 12'h014, 32'h0,         4, 1'b0, 1'b1, 32'hE3A0_0001, 1};
        tbl[1] = '{PD, 2'b10, 12'h000, 32'h0,         5, 1'b0, 1'b0, 32'h0,         1};
        tbl[2] = '{PD, 2'b01, 12'h008, 32'hDEAD_BEEF, 5, 1'b0, 1'b0, 32'h0,         1};
        tbl[3] = '{PF, 2'b00, 12'h008, 32'h0,         4, 1'b0, 1'b1, 32'hDEAD_BEEF, 1};
        tbl[4] = '{PD, 2'b01, 12'h008, 32'h1234_5678, 5, 1'b1, 1'b0, 32'h0,         1};
        tbl[5] = '{PD, 2'b00, 12'h008, 32'h0,         4, 1'b0, 1'b1, 32'hDEAD_BEEF, 1};
        tbl[6] = '{PD, 2'b00, 12'h006, 32'h0,         1, 1'b1, 1'b1, 32'hDEAD_BEEF, 0};
        tbl[7] = '{PD, 2'b11, 12'h00C, 32'h0,         1, 1'b1, 1'b1, 32'hDEAD_BEEF, 0};
        tbl[8] = '{PF, 2'b00, 12'h003, 32'h0,         1, 1'b1, 1'b1, 32'hDEAD_BEEF, 0};

        bus.if_req = 1'b0;  bus.if_addr = '0;  bus.d_req = 1'b0;  bus.d_op = '0;
        bus.d_addr = '0;    bus.d_wdata = '0;
        bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_op = '0;
        bus2.d_addr = '0;   bus2.d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset acks/strobes", 32'({bus.if_ack, bus.if_err, bus.d_ack, bus.d_err,
                                       fl_rd_en, fl_wr_en, fl_erase_en}), 32'd0);
        chk("reset fl_addr", 32'(fl_addr), 32'd0);
        chk("reset fl_idata", fl_idata, 32'd0);
        chk("reset rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        chk("reset dut2 acks", 32'({bus2.if_ack, bus2.d_ack, f2_rd, f2_wr, f2_er}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].port, tbl[i].op, tbl[i].addr, tbl[i].wdata,
                   tbl[i].lat, tbl[i].err, tbl[i].chk_rd, tbl[i].rd, tbl[i].nstrb, 1);
        end

        // Busy never drops in time: abort BUSY_TIMEOUT cycles after entering SETTLE (cycle 3).
        busy_len = 20;
        do_req("timeout", PD, 2'b01, 12'h020, 32'hCAFE_0001, 18, 1'b1, 1'b0, 32'h0, 1, 1);
        repeat (25) @(posedge clk);
        #1;

        // Reset during SETTLE: request dropped, outputs cleared, INIT holds off requests.
        busy_len = 5;
        bus.d_req = 1'b1; bus.d_op = 2'b01; bus.d_addr = 12'h024; bus.d_wdata = 32'h0BAD_F00D;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.d_req = 1'b0;
        bad = 1'b0;
        @(negedge clk);
        if (bus.d_ack || bus.if_ack) bad = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (bus.d_ack || bus.if_ack) bad = 1'b1;
        chk("rst no ack", 32'(bad), 32'd0);
        chk("rst acks/strobes", 32'({bus.if_ack, bus.if_err, bus.d_ack, bus.d_err,
                                     fl_rd_en, fl_wr_en, fl_erase_en}), 32'd0);
        chk("rst fl_addr", 32'(fl_addr), 32'd0);
        chk("rst d_rdata", bus.d_rdata, 32'd0);
        chk("rst if_rdata", bus.if_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        busy_len = 1;
        do_req("post-rst read", PD, 2'b00, 12'h008, 32'h0, 6, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 3);

        // Round-robin ties (last grant was data, so fetch goes first).
        bus.if_req = 1'b1; bus.if_addr = 12'h008;
        bus.d_req = 1'b1;  bus.d_op = 2'b00; bus.d_addr = 12'h008;
        n = 0;
        for (int i = 0; i < 4; i++) begin gport[i] = 1'b1; gk[i] = -1; end
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.if_ack) begin gport[n] = PF; gk[n] = k; n++; end
            else if (bus.d_ack) begin gport[n] = PD; gk[n] = k; n++; end
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        chk("rr grant count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr grant%0d port", i), 32'(gport[i]), 32'(i % 2));
            chk($sformatf("rr grant%0d cycle", i), 32'(gk[i]), 32'(4 + 5 * i));
        end

        // Fixed priority on dut2: fetch served while held, data after it drops.
        bus2.if_req = 1'b1; bus2.if_addr = 12'h004;
        bus2.d_req = 1'b1;  bus2.d_op = 2'b00; bus2.d_addr = 12'h008;
        n = 0; bad = 1'b0;
        for (int i = 0; i < 4; i++) gk[i] = -1;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (bus2.d_ack) bad = 1'b1;
            if (bus2.if_ack) begin
                gk[n] = k; n++;
                chk("prio if_rdata", bus2.if_rdata, 32'hA5A5_0000);
            end
        end
        chk("prio no data ack", 32'(bad), 32'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("prio fetch%0d cycle", i), 32'(gk[i]), 32'(4 + 5 * i));
        @(posedge clk); #1;
        bus2.if_req = 1'b0;
        got = -1;
        for (int k = 0; k < 20 && got < 0; k++) begin
            @(negedge clk);
            if (bus2.d_ack) got = k;
        end
        chk("prio data after fetch drops", 32'(got), 32'd4);
        @(posedge clk); #1;
        bus2.d_req = 1'b0;

        // Lock window on dut2 (words 0..3 protected, erase always rejected).
        lock_req("lock prog 0x00C", 2'b01, 12'h00C, 1, 1'b1, 0);
        lock_req("lock prog 0x010", 2'b01, 12'h010, 4, 1'b0, 1);
        lock_req("lock erase",      2'b10, 12'h000, 1, 1'b1, 0);
        lock_req("lock read 0x00C", 2'b00, 12'h00C, 4, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
